// File: rtl/lane_action_executor_pkg.sv
// Shared action codes and executor state encodings.
// The ALU uses the same action constants.
package lane_action_executor_pkg;

    localparam logic [15:0] ACTION_STOP     = 16'd0;
    localparam logic [15:0] ACTION_LEFT     = 16'd1;
    localparam logic [15:0] ACTION_RIGHT    = 16'd2;
    localparam logic [15:0] ACTION_CONTINUE = 16'd3;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_SHIFT = 2'd2
    } state_t;

endpackage

// File: rtl/lane_action_executor_shift_timer.sv
// lane_shift_timer: steering down-counter with load/abort.
// done is high during the final steering cycle, when the count reaches 0.
module lane_shift_timer (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       load,
    input  logic       abort,
    input  logic [7:0] load_val,
    output logic       done
);

    logic [7:0] count;
    logic       active;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            count  <= 8'd0;
            active <= 1'b0;
        end else if (abort) begin
            active <= 1'b0;
        end else if (load) begin
            active <= 1'b1;
            count  <= load_val;
        end else if (active) begin
            if (count == 8'd0) active <= 1'b0;
            else               count  <= count - 8'd1;
        end
    end

    assign done = active && (count == 8'd0);

endmodule

// File: rtl/lane_action_executor.sv
// Action-stream executor: motor/steering sequencing and car_x lane register.
// Defining WATCHDOG_EN adds an idle watchdog that forces STOP and pulses wdog_trip.
//
// state    | meaning
// ST_IDLE  | motor off, waiting for an action
// ST_RUN   | motor on, waiting for an action
// ST_SHIFT | steering active; returns to IDLE/RUN per run_flag
module lane_action_executor
    import lane_action_executor_pkg::*;
#(
    parameter int MOVE_CYCLES = 4,
    parameter int X_INIT      = 7,
    parameter int X_MAX       = 15
`ifdef WATCHDOG_EN
  , parameter int WDOG_CYCLES = 256
`endif
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [15:0] action_in,
    input  logic        action_valid,
    output logic        action_ready,
    output logic [3:0]  car_x,
    output logic        motor_en,
    output logic        steer_left,
    output logic        steer_right,
    output logic        busy,
    output logic        edge_hit,
    output logic        dropped,
    output logic        bad_action
`ifdef WATCHDOG_EN
  , output logic        wdog_trip
`endif
);

    state_t     state, state_n;
    logic       run_flag, run_n;
    logic       dir_right, dir_n;
    logic [3:0] car_x_n;
    logic       edge_n, drop_n, bad_n;
    logic       load, abort, shift_done;
    logic       stop_req, accepted, force_stop, wdog_expire;

    assign stop_req = action_valid && (action_in == ACTION_STOP);
    assign accepted = action_valid && (action_ready || stop_req);

`ifdef WATCHDOG_EN
    logic [15:0] wdog_cnt;

    // An accepted action in the expiry cycle suppresses the trip.
    assign wdog_expire = run_flag && !accepted && (wdog_cnt == 16'(WDOG_CYCLES - 1));

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wdog_cnt  <= 16'd0;
            wdog_trip <= 1'b0;
        end else begin
            wdog_trip <= wdog_expire;
            if (!run_flag || accepted || wdog_expire) wdog_cnt <= 16'd0;
            else                                      wdog_cnt <= wdog_cnt + 16'd1;
        end
    end
`else
    assign wdog_expire = 1'b0;
`endif

    assign force_stop = stop_req || wdog_expire;

    lane_shift_timer u_timer (
        .clk      (clk),
        .rst_n    (rst_n),
        .load     (load),
        .abort    (abort),
        .load_val (8'(MOVE_CYCLES - 1)),
        .done     (shift_done)
    );

    always_comb begin
        state_n = state;
        run_n   = run_flag;
        dir_n   = dir_right;
        car_x_n = car_x;
        edge_n  = 1'b0;
        drop_n  = 1'b0;
        bad_n   = bad_action;
        load    = 1'b0;
        abort   = 1'b0;
        if (state == ST_SHIFT) begin
            if (force_stop) begin
                abort   = 1'b1;
                state_n = ST_IDLE;
                run_n   = 1'b0;
            end else begin
                if (action_valid) begin
                    drop_n = 1'b1;
                    if (action_in > ACTION_CONTINUE) bad_n = 1'b1;
                end
                if (shift_done) begin
                    car_x_n = dir_right ? car_x + 4'd1 : car_x - 4'd1;
                    state_n = run_flag ? ST_RUN : ST_IDLE;
                end
            end
        end else if (force_stop) begin
            state_n = ST_IDLE;
            run_n   = 1'b0;
        end else if (action_valid) begin
            case (action_in)
                ACTION_CONTINUE: begin
                    state_n = ST_RUN;
                    run_n   = 1'b1;
                end
                ACTION_LEFT: begin
                    if (car_x != 4'd0) begin
                        state_n = ST_SHIFT;
                        dir_n   = 1'b0;
                        load    = 1'b1;
                    end else begin
                        edge_n = 1'b1;
                    end
                end
                ACTION_RIGHT: begin
                    if (car_x < 4'(X_MAX)) begin
                        state_n = ST_SHIFT;
                        dir_n   = 1'b1;
                        load    = 1'b1;
                    end else begin
                        edge_n = 1'b1;
                    end
                end
                default: bad_n = 1'b1;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state        <= ST_IDLE;
            run_flag     <= 1'b0;
            dir_right    <= 1'b0;
            car_x        <= 4'(X_INIT);
            steer_left   <= 1'b0;
            steer_right  <= 1'b0;
            busy         <= 1'b0;
            action_ready <= 1'b1;
            edge_hit     <= 1'b0;
            dropped      <= 1'b0;
            bad_action   <= 1'b0;
        end else begin
            state        <= state_n;
            run_flag     <= run_n;
            dir_right    <= dir_n;
            car_x        <= car_x_n;
            steer_left   <= (state_n == ST_SHIFT) && !dir_n;
            steer_right  <= (state_n == ST_SHIFT) && dir_n;
            busy         <= (state_n == ST_SHIFT);
            action_ready <= (state_n != ST_SHIFT);
            edge_hit     <= edge_n;
            dropped      <= drop_n;
            bad_action   <= bad_n;
        end
    end

    assign motor_en = run_flag;

endmodule

// File: tb/tb_lane_action_executor.sv
// Directed bench for lane_action_executor with a per-cycle behavioural model.
module tb_lane_action_executor;

    localparam int MOVE = 4;
    localparam int XI   = 7;
    localparam int XM   = 15;
`ifdef WATCHDOG_EN
    localparam int WD   = 16;
`endif

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [15:0] action_in = 16'd0;
    logic        action_valid = 1'b0;
    logic        action_ready, motor_en, steer_left, steer_right, busy;
    logic        edge_hit, dropped, bad_action;
    logic [3:0]  car_x;
`ifdef WATCHDOG_EN
    logic        wdog_trip;
`endif

    int total = 0;
    int bad = 0;

    always #5 clk = ~clk;

    lane_action_executor #(
        .MOVE_CYCLES (MOVE),
        .X_INIT      (XI),
        .X_MAX       (XM)
`ifdef WATCHDOG_EN
      , .WDOG_CYCLES (WD)
`endif
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .action_in    (action_in),
        .action_valid (action_valid),
        .action_ready (action_ready),
        .car_x        (car_x),
        .motor_en     (motor_en),
        .steer_left   (steer_left),
        .steer_right  (steer_right),
        .busy         (busy),
        .edge_hit     (edge_hit),
        .dropped      (dropped),
        .bad_action   (bad_action)
`ifdef WATCHDOG_EN
      , .wdog_trip    (wdog_trip)
`endif
    );

    task automatic chk(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s actual=%0d required=%0d at %0t", name, act, exp, $time);
        end
    endtask

    // Model: remaining steering cycles, lane, motor, flags.
    int m_x, rem, m_idle;
    bit m_dir, m_motor, m_bad, m_edge, m_drop, m_trip, started;
    bit acc, stp;

    always @(posedge clk) begin
        if (!rst_n) begin
            m_x = XI; rem = 0; m_dir = 0; m_motor = 0; m_bad = 0;
            m_edge = 0; m_drop = 0; m_trip = 0; m_idle = 0; started = 1;
        end else begin
            stp = action_valid && (action_in == 16'd0);
            acc = action_valid && (rem == 0 || stp);
            m_edge = 0; m_drop = 0; m_trip = 0;
`ifdef WATCHDOG_EN
            if (!m_motor || acc) m_idle = 0;
            else if (m_idle + 1 == WD) begin m_trip = 1; stp = 1; m_idle = 0; end
            else m_idle++;
`endif
            if (stp) begin
                rem = 0; m_motor = 0;
            end else if (rem > 0) begin
                if (action_valid) begin
                    m_drop = 1;
                    if (action_in > 16'd3) m_bad = 1;
                end
                rem--;
                if (rem == 0) m_x = m_dir ? m_x + 1 : m_x - 1;
            end else if (action_valid) begin
                case (action_in)
                    16'd3: m_motor = 1;
                    16'd1: if (m_x == 0) m_edge = 1; else begin rem = MOVE; m_dir = 0; end
                    16'd2: if (m_x == XM) m_edge = 1; else begin rem = MOVE; m_dir = 1; end
                    default: m_bad = 1;
                endcase
            end
        end
    end

    always @(negedge clk) begin
        if (started) begin
            chk("car_x", car_x, m_x);
            chk("motor_en", motor_en, m_motor);
            chk("steer_left", steer_left, (rem > 0 && !m_dir) ? 1 : 0);
            chk("steer_right", steer_right, (rem > 0 && m_dir) ? 1 : 0);
            chk("busy", busy, (rem > 0) ? 1 : 0);
            chk("action_ready", action_ready, (rem == 0) ? 1 : 0);
            chk("edge_hit", edge_hit, m_edge);
            chk("dropped", dropped, m_drop);
            chk("bad_action", bad_action, m_bad);
`ifdef WATCHDOG_EN
            chk("wdog_trip", wdog_trip, m_trip);
`endif
        end
    end

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [15:0] code);
        action_in = code;
        action_valid = 1'b1;
        @(posedge clk);
        #1;
        action_valid = 1'b0;
        action_in = 16'd0;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        idle(2);
        rst_n = 1'b1;
    endtask

    initial begin
        #200000;
        $display("FAIL timeout actual=running required=finished");
        $fatal(1, "time limit");
    end

    initial begin
        int cnt;
        idle(1);
        do_reset();
        chk("lit_reset_car_x", car_x, 7);
        chk("lit_reset_ready", action_ready, 1);
        chk("lit_reset_motor", motor_en, 0);

        send(16'd3);
        chk("lit_continue_motor", motor_en, 1);
        chk("lit_continue_car_x", car_x, 7);

        send(16'd2);
        cnt = 0;
        for (int i = 0; i < 10; i++) begin
            if (steer_right) cnt++;
            idle(1);
        end
        chk("lit_right_cycles", cnt, 4);
        chk("lit_right_car_x", car_x, 8);
        chk("lit_right_motor", motor_en, 1);

        for (int i = 0; i < 8; i++) begin send(16'd1); idle(4); end
        chk("lit_at_zero", car_x, 0);
        send(16'd1);
        chk("lit_edge_left", edge_hit, 1);
        chk("lit_edge_left_steer", steer_left, 0);
        idle(1);
        for (int i = 0; i < 15; i++) begin send(16'd2); idle(4); end
        chk("lit_at_max", car_x, 15);
        send(16'd2);
        chk("lit_edge_right", edge_hit, 1);
        idle(1);

        send(16'd1);
        idle(1);
        send(16'd2);
        chk("lit_dropped", dropped, 1);
        idle(5);
        chk("lit_left_done", car_x, 14);

        send(16'd1);
        idle(1);
        send(16'd0);
        chk("lit_abort_steer", steer_left, 0);
        chk("lit_abort_car_x", car_x, 14);
        chk("lit_abort_motor", motor_en, 0);
        chk("lit_abort_ready", action_ready, 1);
        idle(2);

        send(16'd5);
        chk("lit_bad_set", bad_action, 1);
        send(16'd3);
        send(16'd2);
        send(16'd9);
        idle(5);
        send(16'd0);
        chk("lit_bad_sticky", bad_action, 1);
        chk("lit_bad_car_x", car_x, 15);

        send(16'd1);
        idle(1);
        do_reset();
        chk("lit_rst_mid_car_x", car_x, 7);
        chk("lit_rst_mid_bad", bad_action, 0);
        chk("lit_rst_mid_steer", steer_left, 0);

`ifdef WATCHDOG_EN
        send(16'd3);
        repeat (WD) @(posedge clk);
        #1;
        chk("lit_wdog_trip", wdog_trip, 1);
        chk("lit_wdog_motor", motor_en, 0);
        idle(2);
        send(16'd3);
        idle(WD - 1);
        send(16'd3);
        chk("lit_wdog_no_trip", wdog_trip, 0);
        chk("lit_wdog_motor_on", motor_en, 1);
        send(16'd0);
`endif
        idle(3);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
